nfc_cmd_queue: RTL
==================

Name: nfc_cmd_queue

Overview:
- Command buffer between the AXI-Lite register file command outputs (nfc_opcode/nfc_lba/nfc_len/nfc_valid) and the NFC channel control interface (i_valid/o_ready/i_opc/i_lba/i_len).
- Absorbs back-to-back software command pulses while the channel is busy and re-issues them in order with a valid/ready handshake.
- Provides level, overflow and issue-count status for the register file.

Parameters:
- DEPTH, 8, number of queued commands; power of 2, minimum 2.
- OPC_W, 16, opcode width.
- LBA_W, 48, logical block address width.
- LEN_W, 24, transfer length width.

Ports:
- xdma_clk  input  1  single clock for all logic.
- xdma_resetn  input  1  asynchronous, active-low reset.
- s_valid  input  1  command push pulse from register file; carries no ready.
- s_ready  output  1  high when queue not full.
- s_opc  input  OPC_W  pushed opcode.
- s_lba  input  LBA_W  pushed LBA.
- s_len  input  LEN_W  pushed length.
- m_valid  output  1  command available to channel.
- m_ready  input  1  channel o_ready.
- m_opc  output  OPC_W  head opcode.
- m_lba  output  LBA_W  head LBA.
- m_len  output  LEN_W  head length.
- i_flush  input  1  synchronous discard of all queued commands.
- i_clr_err  input  1  clears sticky overflow.
- o_level  output  $clog2(DEPTH)+1  queued entry count, 0..DEPTH.
- o_overflow  output  1  sticky: push attempted while full.
- o_issued_cnt  output  32  commands handed to channel since reset.

Behaviour:
- Reset (async assert, sync release): wr_ptr, rd_ptr, level = 0; m_valid = 0; s_ready = 1; o_overflow = 0; o_issued_cnt = 0; storage contents don't-care; m_opc/m_lba/m_len = 0.
- Storage: DEPTH-entry flop array; pointers are $clog2(DEPTH) bits plus wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = same index, different wrap bit.
- push = s_valid & ~full.
  - Writes {s_opc,s_lba,s_len} at wr_ptr; wr_ptr+1 wraps naturally.
  - s_ready = ~full, registered from next-state level.
- s_valid & full:
  - Command dropped; no state change except o_overflow <= 1.
  - Applies even if a pop occurs in the same cycle; there is no pass-through when full.
- Output stage: registered head.
  - m_valid and m_* update from the head entry such that a push into an empty queue at cycle N gives m_valid = 1 at N+1.
  - Payload is held stable while m_valid & ~m_ready.
- pop = m_valid & m_ready.
  - rd_ptr+1; o_issued_cnt+1 (wraps 2^32-1 -> 0).
  - The next entry appears on m_* the following cycle; back-to-back pops sustain 1 command/cycle.
- Simultaneous push and pop when not full: level unchanged; both pointers advance.
- Push and pop of the only entry in the same cycle: new entry is presented next cycle, m_valid stays 1.
- o_level = wr_ptr - rd_ptr (modulo, width $clog2(DEPTH)+1); counts the presented head entry; updates the cycle after push/pop.
- i_flush (priority over push/pop):
  - Next cycle: rd_ptr <= wr_ptr, m_valid = 0, level = 0.
  - A push in the flush cycle is discarded.
  - A pop handshake in the flush cycle still counts in o_issued_cnt.
  - o_overflow is unaffected.
- i_clr_err clears o_overflow next cycle; a same-cycle overflow event wins (stays 1).
- Reset mid-operation: all pending commands lost; m_valid drops immediately (async).
- Order is strictly FIFO; no field reordering or modification.

Test Plan:
- Reset, then push opc=0x0080 lba=0x000000001000 len=0x000200 with m_ready=1 -> m_valid one cycle after push with exact fields, o_issued_cnt=1, o_level returns to 0.
- m_ready=0, push 8 commands (opc 0x01..0x08), then a 9th -> s_ready=0 after 8th, o_level=8, o_overflow=1, 9th never issued. Raise m_ready -> opc 0x01..0x08 issued on consecutive cycles, o_issued_cnt=8.
- Queue holds 3, m_ready=1, push every cycle for 20 cycles -> o_level constant at 3, no overflow, output order matches push order.
- Queue holds 5, assert i_flush with simultaneous push -> m_valid=0 and o_level=0 next cycle; subsequent push of opc 0x00A5 is the next issued command.
- o_overflow=1 with i_clr_err asserted alone -> clears to 0. Then i_clr_err coincident with a push-while-full -> o_overflow stays 1.
- Assert xdma_resetn low asynchronously mid-transfer with m_valid=1 -> m_valid, o_level, o_issued_cnt go to 0 without a clock edge; queue accepts a new push after release.

Source files
------------

// File: rtl/nfc_cmd_queue.sv
// Command queue between the register-file command pulses and the NFC channel.
// Registered head stage: a command pushed into an empty queue is presented the next cycle.
module nfc_cmd_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OPC_W = 16,
    parameter int unsigned LBA_W = 48,
    parameter int unsigned LEN_W = 24
) (
    input  logic                       xdma_clk,
    input  logic                       xdma_resetn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [OPC_W-1:0]           s_opc,
    input  logic [LBA_W-1:0]           s_lba,
    input  logic [LEN_W-1:0]           s_len,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OPC_W-1:0]           m_opc,
    output logic [LBA_W-1:0]           m_lba,
    output logic [LEN_W-1:0]           m_len,
    input  logic                       i_flush,
    input  logic                       i_clr_err,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic [31:0]                o_issued_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [LBA_W-1:0] lba;
        logic [LEN_W-1:0] len;
    } cmd_t;

    cmd_t            r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_level;
    logic            r_s_ready;
    logic            r_m_valid;
    cmd_t            r_head;
    logic            r_overflow;
    logic [31:0]     r_issued_cnt;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [PW-1:0]   w_wr_nxt;
    logic [PW-1:0]   w_rd_nxt;
    logic [PW-1:0]   w_lvl_nxt;
    cmd_t            w_s_cmd;
    cmd_t            w_head_nxt;

    // Full: same slot index, opposite wrap bit.
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_push    = s_valid && !w_full && !i_flush;
    assign w_pop     = r_m_valid && m_ready;
    assign w_s_cmd   = '{opc: s_opc, lba: s_lba, len: s_len};
    assign w_wr_nxt  = r_wr_ptr + PW'(w_push);
    assign w_rd_nxt  = i_flush ? r_wr_ptr : (r_rd_ptr + PW'(w_pop));
    assign w_lvl_nxt = w_wr_nxt - w_rd_nxt;

    // Next head bypasses the array when it is the entry being written this cycle.
    assign w_head_nxt = (w_push && (w_rd_nxt == r_wr_ptr)) ? w_s_cmd : r_mem[w_rd_nxt[AW-1:0]];

    // Storage array, no reset needed.
    always_ff @(posedge xdma_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_s_cmd;
        end
    end

    always_ff @(posedge xdma_clk or negedge xdma_resetn) begin
        if (!xdma_resetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_s_ready    <= 1'b1;
            r_m_valid    <= 1'b0;
            r_head       <= '0;
            r_overflow   <= 1'b0;
            r_issued_cnt <= '0;
        end else begin
            r_wr_ptr  <= w_wr_nxt;
            r_rd_ptr  <= w_rd_nxt;
            r_level   <= w_lvl_nxt;
            r_s_ready <= (w_lvl_nxt != PW'(DEPTH));
            r_m_valid <= (w_lvl_nxt != '0);
            if (w_lvl_nxt != '0) begin
                r_head <= w_head_nxt;
            end
            if (w_pop) begin
                r_issued_cnt <= r_issued_cnt + 32'd1;
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (s_valid && w_full) begin
                r_overflow <= 1'b1;
            end else if (i_clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign s_ready      = r_s_ready;
    assign m_valid      = r_m_valid;
    assign m_opc        = r_head.opc;
    assign m_lba        = r_head.lba;
    assign m_len        = r_head.len;
    assign o_level      = r_level;
    assign o_overflow   = r_overflow;
    assign o_issued_cnt = r_issued_cnt;

endmodule
